// File: rtl/gpr_write_bank.sv
// gpr_write_bank: write side of the 32x32 general-purpose register file.
// One-hot write decode, register storage exposed as a flattened bus, a
// registered one-cycle write trace and a saturating committed-write counter.
module gpr_write_bank #(
  parameter int ZERO_HARDWIRED = 1,
  parameter int COUNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [4:0]         waddr,
  input  logic [31:0]        wdata,
  input  logic [31:0]        pc,
  output logic [1023:0]      regs_flat,
  output logic               trace_valid,
  output logic [4:0]         trace_addr,
  output logic [31:0]        trace_data,
  output logic [31:0]        trace_pc,
  output logic [COUNT_W-1:0] wr_count
);

  logic               commit;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               tv_q;
  logic [4:0]         ta_q;
  logic [31:0]        td_q, tp_q;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (&v) return v;
    return v + COUNT_W'(1);
  endfunction

  // Qualify the write: a write to register 0 is dropped when it is hardwired.
  always_comb begin
    commit = we && !((ZERO_HARDWIRED != 0) && (waddr == 5'd0));
    cnt_d  = commit ? sat_inc(cnt_q) : cnt_q;
  end

  // Storage: each register compares waddr against its own index, giving a
  // one-hot decode. Register 0 has no storage when it is hardwired to zero.
  for (genvar i = 0; i < 32; i++) begin : g_reg
    if ((i == 0) && (ZERO_HARDWIRED != 0)) begin : g_zero
      assign regs_flat[31:0] = '0;
    end else begin : g_store
      logic [31:0] r_q;
      // Load this register on a committed write addressed to it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            r_q <= '0;
        else if (commit && (waddr == 5'(i)))   r_q <= wdata;
      end
      assign regs_flat[32*i +: 32] = r_q;
    end
  end

  // Trace pulses for every commit; fields hold the last committed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv_q  <= 1'b0;
      ta_q  <= '0;
      td_q  <= '0;
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tv_q  <= commit;
      cnt_q <= cnt_d;
      if (commit) begin
        ta_q <= waddr;
        td_q <= wdata;
        tp_q <= pc;
      end
    end
  end

  assign trace_valid = tv_q;
  assign trace_addr  = ta_q;
  assign trace_data  = td_q;
  assign trace_pc    = tp_q;
  assign wr_count    = cnt_q;

endmodule

// File: tb/tb_gpr_write_bank.sv
// Bench for gpr_write_bank: two instances (hardwired zero / 16-bit count and
// writable zero / 4-bit count) share one stimulus stream and are compared
// against an array-based reference model, a directed vector table and a few
// hand-written multi-cycle sequences.
module tb_gpr_write_bank;

  logic          clk;
  logic          rst_n;
  logic          we;
  logic [4:0]    waddr;
  logic [31:0]   wdata;
  logic [31:0]   pc;

  logic [1023:0] a_regs, b_regs;
  logic          a_tv, b_tv;
  logic [4:0]    a_ta, b_ta;
  logic [31:0]   a_td, b_td, a_tp, b_tp;
  logic [15:0]   a_cnt;
  logic [3:0]    b_cnt;

  gpr_write_bank #(.ZERO_HARDWIRED(1), .COUNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .pc(pc),
    .regs_flat(a_regs), .trace_valid(a_tv), .trace_addr(a_ta),
    .trace_data(a_td), .trace_pc(a_tp), .wr_count(a_cnt)
  );

  gpr_write_bank #(.ZERO_HARDWIRED(0), .COUNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .pc(pc),
    .regs_flat(b_regs), .trace_valid(b_tv), .trace_addr(b_ta),
    .trace_data(b_td), .trace_pc(b_tp), .wr_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: register arrays, commit totals, last-trace records.
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  int          na, nb;
  logic        etv_a, etv_b;
  logic [68:0] etr_a, etr_b;

  function automatic int sat(input int n, input int w);
    int top;
    top = (1 << w) - 1;
    return (n > top) ? top : n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    na = 0; nb = 0;
    etv_a = 1'b0; etv_b = 1'b0;
    etr_a = '0;   etr_b = '0;
  endtask

  task automatic model_edge();
    etv_a = we && (waddr != 5'd0);
    etv_b = we;
    if (etv_a) begin
      ma[waddr] = wdata;
      na++;
      etr_a = {waddr, wdata, pc};
    end
    if (etv_b) begin
      mb[waddr] = wdata;
      nb++;
      etr_b = {waddr, wdata, pc};
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string name, input logic [1023:0] act, input logic [31:0] m [32]);
    logic [1023:0] exp;
    for (int i = 0; i < 32; i++) exp[32*i +: 32] = m[i];
    ncmp++;
    if (act !== exp) begin
      nfail++;
      for (int i = 0; i < 32; i++) begin
        if (act[32*i +: 32] !== exp[32*i +: 32]) begin
          $display("FAIL %s: reg %0d got %0h expected %0h at %0t",
                   name, i, act[32*i +: 32], exp[32*i +: 32], $time);
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    chk_regs("regs_a", a_regs, ma);
    chk_regs("regs_b", b_regs, mb);
    chk("tvalid_a", 128'(a_tv), 128'(etv_a));
    chk("tvalid_b", 128'(b_tv), 128'(etv_b));
    chk("trace_a", 128'({a_ta, a_td, a_tp}), 128'(etr_a));
    chk("trace_b", 128'({b_ta, b_td, b_tp}), 128'(etr_b));
    chk("count_a", 128'(a_cnt), 128'(sat(na, 16)));
    chk("count_b", 128'(b_cnt), 128'(sat(nb, 4)));
  endtask

  // Drive one cycle's inputs, let the edge happen, then check just after it.
  task automatic cycle(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
    we = w; waddr = a; wdata = d; pc = p;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
    logic        tv;
    logic [4:0]  ta;
    logic [31:0] td;
    logic [31:0] tp;
    int          cnt;
    int          ra;
    logic [31:0] rv;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected values below are for the hardwired-zero, 16-bit-count instance.
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 32'h3000, 1'b1, 5'd5,  32'hDEADBEEF, 32'h3000, 1, 5,  32'hDEADBEEF};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        32'h0,    1'b0, 5'd5,  32'hDEADBEEF, 32'h3000, 1, 5,  32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd0,  32'h12345678, 32'h3008, 1'b0, 5'd5,  32'hDEADBEEF, 32'h3000, 1, 0,  32'h0};
    tbl[3] = '{1'b1, 5'd31, 32'h1,        32'h300C, 1'b1, 5'd31, 32'h1,        32'h300C, 2, 31, 32'h1};
    tbl[4] = '{1'b1, 5'd31, 32'h2,        32'h3010, 1'b1, 5'd31, 32'h2,        32'h3010, 3, 31, 32'h2};
    tbl[5] = '{1'b1, 5'd1,  32'hFFFFFFFF, 32'h3014, 1'b1, 5'd1,  32'hFFFFFFFF, 32'h3014, 4, 1,  32'hFFFFFFFF};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        32'h0,    1'b0, 5'd1,  32'hFFFFFFFF, 32'h3014, 4, 31, 32'h2};

    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].p);
      chk($sformatf("tbl%0d_tvalid", i), 128'(a_tv), 128'(tbl[i].tv));
      chk($sformatf("tbl%0d_trace", i), 128'({a_ta, a_td, a_tp}), 128'({tbl[i].ta, tbl[i].td, tbl[i].tp}));
      chk($sformatf("tbl%0d_count", i), 128'(a_cnt), 128'(tbl[i].cnt));
      chk($sformatf("tbl%0d_reg", i), 128'(a_regs[32*tbl[i].ra +: 32]), 128'(tbl[i].rv));
    end
    chk("b_reg0_writable", 128'(b_regs[31:0]), 128'(32'h12345678));
    chk("b_count_after_tbl", 128'(b_cnt), 128'(5));

    // No bypass: the write data must not show before the edge.
    we = 1'b1; waddr = 5'd7; wdata = 32'hA; pc = 32'h4000;
    #3;
    chk("nobypass_before", 128'(a_regs[7*32 +: 32]), 128'(ma[7]));
    @(posedge clk);
    model_edge();
    #1;
    chk("nobypass_after", 128'(a_regs[7*32 +: 32]), 128'(32'hA));
    check_all();

    // Asynchronous reset between edges with registers loaded.
    we = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++) cycle(1'b1, 5'd3, 32'(i + 100), 32'h5000 + 32'(4 * i));
    chk("b_count_sat", 128'(b_cnt), 128'(15));
    cycle(1'b0, 5'd0, 32'h0, 32'h0);
    chk("b_count_sat_hold", 128'(b_cnt), 128'(15));
    chk("a_count_20", 128'(a_cnt), 128'(20));

    // Reset asserted in the same cycle as a write discards it.
    we = 1'b1; waddr = 5'd9; wdata = 32'h55; pc = 32'h6000;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    chk("rst_mid_reg9", 128'(a_regs[9*32 +: 32]), 128'(0));
    chk("rst_mid_count_b", 128'(b_cnt), 128'(0));
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 200; i++)
      cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
